// File: rtl/fetch_prefetch_pkg.sv
// Shared types and constants for the prefetching fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_N       = 32;
  localparam int unsigned PC_PLUS8_MULT = 2;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_N-1:0] instr;
    logic [FETCH_N-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_if.sv
// Request/response bus between the fetch stage and instruction memory.
interface fetch_prefetch_if #(
  parameter int unsigned N = 32
);
  logic         ImemReq;
  logic [N-1:0] ImemAddr;
  logic         ImemReady;
  logic         ImemValid;
  logic [N-1:0] ImemRdata;

  modport master (
    output ImemReq, ImemAddr,
    input  ImemReady, ImemValid, ImemRdata
  );

  modport slave (
    input  ImemReq, ImemAddr,
    output ImemReady, ImemValid, ImemRdata
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Synchronous FIFO of fetched instructions with flush; head is visible
// combinationally and reads as zero while the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned CW     = $clog2(DEPTH + 1),
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          full;

  always_comb begin
    do_pop = pop && (count != '0);
    full   = (count == CW'(DEPTH));
    head   = (count != '0) ? mem[rd_ptr] : '0;
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap on the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && full)) else $error("fetch_queue: push into full queue");
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Prefetching fetch stage: issues in-order requests to instruction memory,
// buffers responses in a small queue and flushes everything on redirect.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_STEP  = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        ResultW,
  input  logic [N-1:0]        ExtImmE,
  input  logic                PCSrcW,
  input  logic                BranchTakenE,
  input  logic                StallF,
  fetch_prefetch_if.master    imem,
  output logic                ValidD,
  output logic [N-1:0]        InstrD,
  output logic [N-1:0]        PCD,
  output logic [N-1:0]        PCPlus8D
);

  localparam int unsigned  CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]  LIMIT   = (CW + 1)'(DEPTH);
  localparam logic [N-1:0] STEP    = N'(PC_STEP);
  localparam logic [N-1:0] PLUS8   = N'(PC_PLUS8_MULT * PC_STEP);

  typedef struct packed {
    logic [N-1:0] instr;
    logic [N-1:0] pc;
  } entry_t;

  logic          rst_q;
  logic [N-1:0]  pc;
  logic [N-1:0]  resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;

  logic          redirect;
  logic [N-1:0]  target;
  logic          credit_ok;
  logic          req;
  logic          issue;
  logic          resp;
  logic          drop;
  logic          push;
  logic          pop;
  entry_t        push_entry;
  entry_t        head;

  // Redirect selection, request credit and response routing.
  always_comb begin
    redirect   = BranchTakenE | PCSrcW;
    target     = BranchTakenE ? ExtImmE : ResultW;
    credit_ok  = ({1'b0, count} + {1'b0, outstanding}) < LIMIT;
    req        = !rst && !rst_q && !redirect && credit_ok;
    issue      = req && imem.ImemReady;
    resp       = imem.ImemValid && (outstanding != '0);
    drop       = resp && (discard != '0);
    push       = resp && (discard == '0) && !redirect;
    pop        = ValidD && !StallF && !redirect;
    push_entry = '{instr: imem.ImemRdata, pc: resp_pc};
  end

  always_comb begin
    imem.ImemReq  = req;
    imem.ImemAddr = pc;
    ValidD        = (count != '0);
    InstrD        = head.instr;
    PCD           = head.pc;
    PCPlus8D      = head.pc + PLUS8;
  end

  // PC, response PC and credit/discard bookkeeping. On redirect every
  // request still in flight after this cycle's response becomes stale; this
  // already covers any discards pending from an earlier redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q       <= 1'b1;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      rst_q <= 1'b0;
      if (redirect) begin
        pc          <= target;
        resp_pc     <= target;
        outstanding <= outstanding - CW'(resp);
        discard     <= outstanding - CW'(resp);
      end else begin
        if (issue) begin
          pc <= pc + STEP;
        end
        if (push) begin
          resp_pc <= resp_pc + STEP;
        end
        outstanding <= outstanding + CW'(issue) - CW'(resp);
        discard     <= discard - CW'(drop);
      end
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .clear (redirect),
    .count (count),
    .head  (head)
  );

endmodule
